// File: rtl/exe_div_seq_pkg.sv
// Shared definitions for the execute-stage divide sequencer.
// Operation codes, state encoding and magnitude helper.
package exe_div_seq_pkg;

    localparam int XLEN     = 32;
    localparam int DIV_ITER = 32;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

endpackage

// File: rtl/exe_div_seq.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU/REM/REMU.
// Holds the pipeline via stall_req_o until a registered result is ready.
module exe_div_seq
    import exe_div_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  flush_i,
    output logic                  stall_req_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [4:0]            reg_waddr_o
);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LAST    = CNT_WIDTH'(DIV_ITER - 1);

    div_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [2:0]            funct3_q;
    logic [4:0]            waddr_q;
    logic                  sign1_q;
    logic                  sign2_q;
    logic [DATA_WIDTH-1:0] quot_q;
    logic [DATA_WIDTH-1:0] dvsr_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] result_q;

    logic                  accept;
    logic                  in_signed;
    logic                  in_rem;
    logic                  div_zero;
    logic                  ovf;
    logic                  special;
    logic [DATA_WIDTH-1:0] special_res;

    logic                  q_rem;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   diff;
    logic                  fits;
    logic [DATA_WIDTH-1:0] rem_nx;
    logic [DATA_WIDTH-1:0] quot_nx;
    logic [DATA_WIDTH-1:0] quot_fin;
    logic [DATA_WIDTH-1:0] rem_fin;
    logic [DATA_WIDTH-1:0] calc_res;
    logic                  unused_diff_msb;

    // Operand decode for the instruction currently offered in IDLE
    assign accept    = (state_q == DIV_IDLE) && start_i && !flush_i;
    assign in_signed = (funct3_i == INST_DIV) || (funct3_i == INST_REM);
    assign in_rem    = (funct3_i == INST_REM) || (funct3_i == INST_REMU);
    assign div_zero  = (op2_i == '0);
    assign ovf       = in_signed && (op1_i == MIN_NEG) && (op2_i == '1);
    assign special   = div_zero || ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = in_rem ? op1_i : '1;
        else
            special_res = in_rem ? '0 : MIN_NEG;
    end

    // One restoring step: shift {rem, quot} and trial-subtract the divisor
    assign q_rem   = (funct3_q == INST_REM) || (funct3_q == INST_REMU);
    assign rem_sh  = {rem_q, quot_q[DATA_WIDTH-1]};
    assign fits    = rem_sh >= {1'b0, dvsr_q};
    assign diff    = rem_sh - {1'b0, dvsr_q};
    assign rem_nx  = fits ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
    assign quot_nx = {quot_q[DATA_WIDTH-2:0], fits};

    assign unused_diff_msb = diff[DATA_WIDTH];

    assign quot_fin = (sign1_q ^ sign2_q) ? -quot_nx : quot_nx;
    assign rem_fin  = sign1_q ? -rem_nx : rem_nx;
    assign calc_res = q_rem ? rem_fin : quot_fin;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= DIV_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (accept)
                    state_d = special ? DIV_DONE : DIV_CALC;
            end
            DIV_CALC: begin
                if (flush_i)
                    state_d = DIV_IDLE;
                else if (cnt_q == LAST)
                    state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            funct3_q <= '0;
            waddr_q  <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            funct3_q <= funct3_i;
            waddr_q  <= reg_waddr_i;
            sign1_q  <= in_signed && op1_i[DATA_WIDTH-1];
            sign2_q  <= in_signed && op2_i[DATA_WIDTH-1];
            quot_q   <= in_signed ? abs_val(op1_i) : op1_i;
            dvsr_q   <= in_signed ? abs_val(op2_i) : op2_i;
            rem_q    <= '0;
            cnt_q    <= '0;
            if (special)
                result_q <= special_res;
        end else if (state_q == DIV_CALC && !flush_i) begin
            rem_q  <= rem_nx;
            quot_q <= quot_nx;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LAST)
                result_q <= calc_res;
        end
    end

    assign stall_req_o = accept || (state_q == DIV_CALC);
    assign busy_o      = (state_q != DIV_IDLE);
    assign done_o      = (state_q == DIV_DONE) && !flush_i;
    assign result_o    = result_q;
    assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_exe_div_seq.sv
// Randomized and directed bench for exe_div_seq.
// Expected values come from plain SystemVerilog arithmetic.
module tb_exe_div_seq;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    int checks;
    int errors;
    logic [31:0] last_res;

    localparam logic [31:0] MINV = 32'h8000_0000;

    exe_div_seq dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .funct3_i    (funct3_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .reg_waddr_i (reg_waddr_i),
        .flush_i     (flush_i),
        .stall_req_o (stall_req_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .reg_waddr_o (reg_waddr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int signed sa;
        int signed sb;
        bit ov;
        sa = a;
        sb = b;
        ov = (a == MINV) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ov ? MINV : 32'(sa / sb);
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : ov ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input bit hold);
        logic [31:0] exp;
        int lat;
        int cyc;
        int stalls;
        bit seen;
        exp = ref_div(f, a, b);
        lat = (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF)) ? 1 : 33;
        @(posedge clk_i);
        #1;
        start_i     = 1'b1;
        funct3_i    = f;
        op1_i       = a;
        op2_i       = b;
        reg_waddr_i = wa;
        #1;
        chk("stall_start", 32'(stall_req_o), 32'd1);
        stalls = stall_req_o ? 1 : 0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (!hold)
                start_i = 1'b0;
            if (done_o) begin
                seen = 1;
                start_i = 1'b0;
                chk("latency", 32'(cyc), 32'(lat));
                chk("result", result_o, exp);
                chk("waddr", 32'(reg_waddr_o), 32'(wa));
                chk("stall_done", 32'(stall_req_o), 32'd0);
                chk("busy_done", 32'(busy_o), 32'd1);
            end else if (stall_req_o) begin
                stalls++;
            end
        end
        start_i = 1'b0;
        if (!seen)
            chk("timeout", 32'd0, 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(lat));
        @(posedge clk_i);
        #1;
        chk("result_hold", result_o, exp);
        last_res = exp;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return MINV;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        last_res = '0;
        rst_i = 1'b1;
        start_i = 1'b0;
        funct3_i = 3'b0;
        op1_i = '0;
        op2_i = '0;
        reg_waddr_i = '0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_result", result_o, 32'h0);
        chk("rst_waddr", 32'(reg_waddr_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_stall", 32'(stall_req_o), 32'h0);
        rst_i = 1'b0;

        run_op(3'b101, 32'd100, 32'd7, 5'd3, 0);
        run_op(3'b111, 32'd100, 32'd7, 5'd4, 0);
        run_op(3'b100, -32'd7, 32'd2, 5'd5, 0);
        run_op(3'b110, -32'd7, 32'd2, 5'd6, 0);
        run_op(3'b100, 32'd7, -32'd2, 5'd7, 0);
        run_op(3'b100, 32'd5, 32'd0, 5'd8, 0);
        run_op(3'b110, 32'd5, 32'd0, 5'd9, 0);
        run_op(3'b100, MINV, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(3'b110, MINV, 32'hFFFF_FFFF, 5'd11, 0);

        // Flush in the middle of an iteration run
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        funct3_i = 3'b101;
        op1_i = 32'd1000;
        op2_i = 32'd3;
        reg_waddr_i = 5'd12;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_done", 32'(done_o), 32'd0);
        chk("flush_stall", 32'(stall_req_o), 32'd0);
        chk("flush_result", result_o, last_res);
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (done_o)
                chk("flush_no_done", 32'(done_o), 32'd0);
        end

        run_op(3'b101, 32'd9, 32'd3, 5'd13, 0);
        run_op(3'b101, 32'd1000, 32'd7, 5'd14, 1);

        // Asynchronous reset during CALC
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        funct3_i = 3'b101;
        op1_i = 32'd12345;
        op2_i = 32'd11;
        reg_waddr_i = 5'd15;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("arst_result", result_o, 32'h0);
        chk("arst_waddr", 32'(reg_waddr_o), 32'h0);
        chk("arst_busy", 32'(busy_o), 32'h0);
        chk("arst_done", 32'(done_o), 32'h0);
        chk("arst_stall", 32'(stall_req_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd16, 0);

        for (int i = 0; i < 60; i++) begin
            run_op(3'(4 + $urandom_range(0, 3)), pick_op(), pick_op(),
                   5'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
